// File: rtl/imem_loader.sv
// Instruction memory loader: parses framed byte stream (SYNC, N, N x {HI,LO}, XOR checksum),
// writes 12-bit instructions at sequential addresses and holds the CPU until a good program lands.
module imem_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 12,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam int unsigned REM_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [REM_W-1:0]   rem, rem_nxt;
    logic [ADDR_W-1:0]  addr_cnt, addr_nxt;
    logic [7:0]         csum, csum_nxt;
    logic [3:0]         hi_nib, hi_nxt;
    logic               wr_en_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [INSTR_W-1:0] wr_data_nxt;
    logic               cpu_hold_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic               accept_c;

    assign accept_c = in_valid && in_ready;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rem      <= '0;
            addr_cnt <= '0;
            csum     <= '0;
            hi_nib   <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rem      <= rem_nxt;
            addr_cnt <= addr_nxt;
            csum     <= csum_nxt;
            hi_nib   <= hi_nxt;
            in_ready <= 1'b1;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            cpu_hold <= cpu_hold_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // Next-state and next-output logic; nothing moves without an accepted byte
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        addr_nxt    = addr_cnt;
        csum_nxt    = csum;
        hi_nxt      = hi_nib;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = 1'b0;

        if (accept_c) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_data == SYNC) begin
                        state_nxt = S_COUNT;
                    end
                end
                S_COUNT: begin
                    // N == 0 encodes a full 256-instruction program
                    rem_nxt   = (in_data == 8'h00) ? REM_W'(256) : REM_W'(in_data);
                    addr_nxt  = '0;
                    csum_nxt  = in_data;
                    state_nxt = S_HI;
                end
                S_HI: begin
                    if (in_data[7:4] != 4'h0) begin
                        state_nxt = S_ERR;
                    end else begin
                        hi_nxt    = in_data[3:0];
                        csum_nxt  = csum ^ in_data;
                        state_nxt = S_LO;
                    end
                end
                S_LO: begin
                    csum_nxt    = csum ^ in_data;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr_cnt;
                    wr_data_nxt = INSTR_W'({hi_nib, in_data});
                    addr_nxt    = addr_cnt + ADDR_W'(1);
                    rem_nxt     = rem - REM_W'(1);
                    state_nxt   = (rem != REM_W'(1)) ? S_HI : S_CSUM;
                end
                S_CSUM: begin
                    if (in_data == csum) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        cpu_hold_nxt = (state_nxt != S_DONE);
        err_nxt      = (state_nxt == S_ERR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected writes plus per-scenario status checks.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          vectors;
    int          miscompares;
    logic [19:0] exp_q[$];
    logic [11:0] prog [256];

    imem_loader #(.ADDR_W(8), .INSTR_W(12), .SYNC(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the scoreboard whenever the DUT strobes a write
    task automatic check_wr();
        logic [19:0] e;
        if (wr_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%02h data=%03h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr=%02h data=%03h, required addr=%02h data=%03h",
                             wr_addr, wr_data, e[19:12], e[11:0]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check_wr();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        if (gaps) begin
            g = int'($urandom_range(0, 2));
            for (int i = 0; i < g; i++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk);
                #1;
                check_wr();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_wr();
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    // Full frame from prog[]; checksum optionally corrupted by flipping bit 0
    task automatic load_frame(input int n, input bit corrupt, input bit gaps);
        int         cnt;
        logic [7:0] cs;
        logic [7:0] hi;
        logic [7:0] lo;
        cnt = (n == 0) ? 256 : n;
        send_byte(8'hA5, gaps);
        check_bit("sync_hold", cpu_hold, 1'b1);
        send_byte(8'(n), gaps);
        cs = 8'(n);
        for (int i = 0; i < cnt; i++) begin
            hi = {4'h0, prog[i][11:8]};
            lo = prog[i][7:0];
            cs = cs ^ hi ^ lo;
            send_byte(hi, gaps);
            exp_q.push_back({8'(i), prog[i]});
            send_byte(lo, gaps);
        end
        if (corrupt) cs = cs ^ 8'h01;
        send_byte(cs, gaps);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        check_bit(corrupt ? "csum_bad_done" : "csum_done", done, !corrupt);
        check_bit(corrupt ? "csum_bad_err" : "csum_err", err, corrupt);
        check_bit(corrupt ? "csum_bad_hold" : "csum_hold", cpu_hold, corrupt);
        idle(1);
        check_bit("done_one_cycle", done, 1'b0);
        check_bit("hold_after", cpu_hold, corrupt);
    endtask

    task automatic set_basic();
        prog[0] = 12'h123;
        prog[1] = 12'hABC;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_wr_en", wr_en, 1'b0);
        vectors++;
        if (wr_addr !== 8'h00 || wr_data !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_wr_bus: got addr=%02h data=%03h, required 00/000", wr_addr, wr_data);
        end
        check_bit("rst_hold", cpu_hold, 1'b1);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check_bit("ready_after_rst", in_ready, 1'b1);
    endtask

    task automatic test_garbage();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(1);
        check_bit("garbage_hold", cpu_hold, 1'b1);
        check_bit("garbage_err", err, 1'b0);
        check_bit("garbage_done", done, 1'b0);
    endtask

    task automatic test_basic();
        set_basic();
        load_frame(2, 1'b0, 1'b0);
        check_bit("basic_err", err, 1'b0);
    endtask

    task automatic test_bad_csum();
        set_basic();
        load_frame(2, 1'b1, 1'b0);
        idle(2);
        check_bit("bad_err_stays", err, 1'b1);
        load_frame(2, 1'b0, 1'b0);
        check_bit("recover_err", err, 1'b0);
    endtask

    task automatic test_illegal_hi();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        check_bit("ill_hi_err", err, 1'b1);
        check_bit("ill_hi_hold", cpu_hold, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h22, 1'b0);
        check_bit("ill_hi_ignored", err, 1'b1);
        set_basic();
        load_frame(2, 1'b0, 1'b0);
    endtask

    task automatic test_full_256();
        for (int i = 0; i < 256; i++) prog[i] = 12'(i);
        load_frame(0, 1'b0, 1'b0);
    endtask

    task automatic test_reload();
        // previous frame ended in DONE; new frame must restart at address 0
        prog[0] = 12'h5A5;
        prog[1] = 12'h00F;
        prog[2] = 12'hF00;
        load_frame(3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        rst = 1'b1;
        #1;
        check_bit("midrst_hold", cpu_hold, 1'b1);
        check_bit("midrst_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h23;
        @(posedge clk);
        #1;
        check_bit("midrst_no_write", wr_en, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send_byte(8'h23, 1'b0);
        idle(1);
        check_bit("midrst_idle_hold", cpu_hold, 1'b1);
        check_bit("midrst_idle_err", err, 1'b0);
        set_basic();
        load_frame(2, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        set_basic();
        load_frame(2, 1'b0, 1'b1);
        load_frame(2, 1'b1, 1'b1);
        load_frame(2, 1'b0, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_garbage();
        test_basic();
        test_bad_csum();
        test_illegal_hi();
        test_full_256();
        test_reload();
        test_reset_mid_frame();
        test_stalls();
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
